// File: rtl/led_pkg.sv
// Shared definitions for the LED pulse stretcher: channel state encoding
// and the helper that sizes the per-channel down-counter.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } led_state_e;

  // Counter must hold the larger of the two reload values.
  function automatic int cnt_width(input int on_cycles, input int gap_cycles);
    int max_cycles;
    max_cycles = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/led_pulse_array_if.sv
// Event inputs, mode selects and LED/busy outputs of the pulse stretcher
// array, bundled so the top level and its driver share one port list.
interface led_pulse_array_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] trig_in;
  logic [CH_NUM-1:0] mode_retrig;
  logic [CH_NUM-1:0] led_out;
  logic [CH_NUM-1:0] busy;

  // Driver side: issues events, observes LEDs.
  modport master (
    output trig_in,
    output mode_retrig,
    input  led_out,
    input  busy
  );

  // Stretcher side.
  modport slave (
    input  trig_in,
    input  mode_retrig,
    output led_out,
    output busy
  );
endinterface

// File: rtl/led_pulse_chan.sv
// One pulse stretcher channel: input synchroniser, rising-edge detect,
// IDLE/ON/GAP state machine with a shared down-counter and a one-deep
// pending flag for queue mode. Output "lit" is active-high; polarity is
// applied by the top level.
module led_pulse_chan
  import led_pkg::*;
#(
  parameter int ON_CYCLES  = 2_500_000,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic trig_in,
  input  logic mode_retrig,
  output logic lit,
  output logic busy
);

  localparam int CW = cnt_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  logic          trig_d1_reg;
  logic          trig_d2_reg;
  logic          rise;
  led_state_e    state_reg;
  led_state_e    state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          pending_reg;
  logic          pending_next;
  logic          lit_reg;
  logic          busy_reg;

  // Two-flop synchroniser for the asynchronous event input.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      trig_d1_reg <= 1'b0;
      trig_d2_reg <= 1'b0;
    end else begin
      trig_d1_reg <= trig_in;
      trig_d2_reg <= trig_d1_reg;
    end
  end

  assign rise = trig_d1_reg & ~trig_d2_reg;

  // Next-state logic: first the counter-driven transition, then any rise is
  // applied against the state we are heading into, so a rise that lands on
  // a count boundary is never lost.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_ON: begin
        if (cnt_reg == '0) begin
          if (HAS_GAP) begin
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
          end else if (pending_reg) begin
            state_next   = ST_ON;
            cnt_next     = ON_LOAD;
            pending_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_reg == '0) begin
          if (pending_reg) begin
            state_next   = ST_ON;
            cnt_next     = ON_LOAD;
            pending_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next   = ST_IDLE;
        cnt_next     = '0;
        pending_next = 1'b0;
      end
    endcase

    if (rise) begin
      case (state_next)
        ST_IDLE: begin
          state_next = ST_ON;
          cnt_next   = ON_LOAD;
        end
        ST_ON: begin
          if (mode_retrig) begin
            cnt_next = ON_LOAD;
          end else begin
            pending_next = 1'b1;  // a second queued event is simply dropped
          end
        end
        ST_GAP: begin
          if (mode_retrig) begin
            state_next = ST_ON;
            cnt_next   = ON_LOAD;
          end else begin
            pending_next = 1'b1;
          end
        end
        default: begin
          state_next = state_next;
        end
      endcase
    end
  end

  // State, counter, pending flag and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      lit_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      lit_reg     <= (state_next == ST_ON);
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  assign lit  = lit_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/led_pulse_array.sv
// Multi-channel LED pulse stretcher. Each channel is an independent
// led_pulse_chan; the top only replicates them and sets LED polarity.
module led_pulse_array
  import led_pkg::*;
#(
  parameter int CH_NUM         = 4,
  parameter int ON_CYCLES      = 2_500_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  led_pulse_array_if.slave bus
);

  // XOR mask turning the active-high lit flags into the board's LED level.
  localparam logic [CH_NUM-1:0] POLARITY_MASK = LED_ACTIVE_LOW ? {CH_NUM{1'b1}} : {CH_NUM{1'b0}};

  logic [CH_NUM-1:0] lit_vec;
  logic [CH_NUM-1:0] busy_vec;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
      led_pulse_chan #(
        .ON_CYCLES  (ON_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
      ) u_chan (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .trig_in     (bus.trig_in[gi]),
        .mode_retrig (bus.mode_retrig[gi]),
        .lit         (lit_vec[gi]),
        .busy        (busy_vec[gi])
      );
    end
  endgenerate

  assign bus.led_out = lit_vec ^ POLARITY_MASK;
  assign bus.busy    = busy_vec;

endmodule

// File: tb/tb_led_pulse_array.sv
// Scoreboard bench for led_pulse_array (CH_NUM=4, ON=5, GAP=3, active-low).
// Stimulus strings give per-cycle trig levels; expectation strings give the
// per-cycle channel state after that edge: I = idle, L = lit, D = dark gap.
module tb_led_pulse_array;

  localparam int CH = 4;

  logic sys_clk;
  logic sys_rst;

  led_pulse_array_if #(.CH_NUM(CH)) bus ();

  led_pulse_array #(
    .CH_NUM         (CH),
    .ON_CYCLES      (5),
    .GAP_CYCLES     (3),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  typedef struct {
    logic [CH-1:0] led;
    logic [CH-1:0] busy;
    string         tag;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic void check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic byte char_at(input string s, input int i, input byte pad);
    if (i < s.len()) return s[i];
    return pad;
  endfunction

  // Monitor: one transaction per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d].led_out", e.tag, e.cyc), bus.led_out, e.led);
        check($sformatf("%s[%0d].busy", e.tag, e.cyc), bus.busy, e.busy);
        $display("txn %s cyc=%0d led_out=%h busy=%h (req %h/%h)",
                 e.tag, e.cyc, bus.led_out, bus.busy, e.led, e.busy);
      end
    end
  end

  task automatic run(input string tag, input logic [CH-1:0] mode,
                     input string t0, input string t1, input string t2, input string t3,
                     input string e0, input string e1, input string e2, input string e3);
    string ts[CH];
    string es[CH];
    int    len;
    exp_t  e;
    ts = '{t0, t1, t2, t3};
    es = '{e0, e1, e2, e3};
    len = 0;
    for (int c = 0; c < CH; c++) begin
      if (ts[c].len() > len) len = ts[c].len();
      if (es[c].len() > len) len = es[c].len();
    end
    for (int i = 0; i < len; i++) begin
      bus.mode_retrig = mode;
      for (int c = 0; c < CH; c++) bus.trig_in[c] = (char_at(ts[c], i, "0") == "1");
      @(posedge sys_clk);
      #1;
      e.tag = tag;
      e.cyc = i;
      for (int c = 0; c < CH; c++) begin
        case (char_at(es[c], i, "I"))
          "L":     begin e.led[c] = 1'b0; e.busy[c] = 1'b1; end
          "D":     begin e.led[c] = 1'b1; e.busy[c] = 1'b1; end
          default: begin e.led[c] = 1'b1; e.busy[c] = 1'b0; end
        endcase
      end
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst         = 1'b1;
    bus.trig_in     = '0;
    bus.mode_retrig = '0;
    #1;
    check("reset.led_out", bus.led_out, 4'hF);
    check("reset.busy", bus.busy, 4'h0);
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;

    run("post_reset", 4'b0000, "000", "", "", "", "III", "", "", "");

    run("single", 4'b0000, "1", "", "", "", "ILLLLLDDDII", "", "", "");

    run("retrig", 4'b0001, "10010000000000", "", "", "",
        "ILLLLLLLLDDDII", "", "", "");

    run("queue", 4'b0000, "1010001000000000000", "", "", "",
        "ILLLLLDDDLLLLLDDDII", "", "", "");

    // ch0 retriggers out of GAP; ch2 queues a rise on the GAP-end cycle.
    run("boundary", 4'b0001, "100000100000000000", "", "100000001000000000", "",
        "ILLLLLDLLLLLDDDIII", "", "ILLLLLDDDLLLLLDDDI", "");

    run("level", 4'b0000, "", "111111111111111111110000", "", "111111111111111111110000",
        "", "ILLLLLDDDIIIIIIIIIIIIIII", "", "ILLLLLDDDIIIIIIIIIIIIIII");

    // Reset in the middle of a flash with the input still held high.
    run("pre_rst", 4'b0000, "", "", "1111", "", "", "", "ILLL", "");
    @(negedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("rst_mid.led_out", bus.led_out, 4'hF);
    check("rst_mid.busy", bus.busy, 4'h0);
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    run("post_rst", 4'b0000, "", "", "1111111111100", "", "", "", "ILLLLLDDDIIII", "");

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge sys_clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
